// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared widths, phase encodings and colour-order constants
package ws2812b_pkg;

   localparam int PIXEL_W   = 24;
   localparam int ENTRY_W   = PIXEL_W + 1;
   localparam int ORDER_RGB = 0;
   localparam int ORDER_GRB = 1;

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } phase_t;

endpackage

// File: rtl/ws2812b_pixel_feeder_if.sv
// rtl/ws2812b_pixel_feeder_if.sv - byte write port and pixel stream handshake bundle
interface ws2812b_pixel_feeder_if;

   logic [7:0]                     wr_data;
   logic                           wr_en;
   logic                           wr_latch;
   logic                           wr_ready;
   logic [ws2812b_pkg::PIXEL_W-1:0] pix_data;
   logic                           pix_valid;
   logic                           pix_latch;
   logic                           pix_ready;

   // Environment side: CPU byte writer plus downstream serial driver.
   modport master (
      output wr_data, wr_en, wr_latch, pix_ready,
      input  wr_ready, pix_data, pix_valid, pix_latch
   );

   // Feeder side.
   modport slave (
      input  wr_data, wr_en, wr_latch, pix_ready,
      output wr_ready, pix_data, pix_valid, pix_latch
   );

endinterface

// File: rtl/ws2812b_sync_fifo.sv
// rtl/ws2812b_sync_fifo.sv - show-ahead synchronous FIFO with explicit level counter
module ws2812b_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 25
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Guards keep the FIFO self-consistent even if the caller misbehaves.
   assign do_push = push && (level != FULL) && !flush;
   assign do_pop  = pop && (level != '0) && !flush;

   // Head is read combinationally at the read pointer (show-ahead).
   assign head = mem[rd_ptr];

   // Storage array; cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally; level is tracked separately from them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ws2812b_pixel_feeder.sv
// rtl/ws2812b_pixel_feeder.sv - assembles R,G,B bytes into queued 24-bit pixel words
module ws2812b_pixel_feeder
   import ws2812b_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int GRB_ORDER = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ws2812b_pixel_feeder_if.slave    bus,
   input  logic                     abort,
   input  logic                     clr_ovf,
   output logic [$clog2(DEPTH):0]   level,
   output logic [1:0]               phase,
   output logic                     busy,
   output logic                     overflow
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   phase_t               state;
   phase_t               state_next;
   logic [7:0]           r_q;
   logic [7:0]           g_q;
   logic                 accept;
   logic                 reject;
   logic                 push;
   logic                 pop;
   logic [PIXEL_W-1:0]   word;
   logic [ENTRY_W-1:0]   head;

   // Only the B byte needs FIFO space, so R and G are always accepted.
   assign bus.wr_ready = (state != PH_B) || (level != FULL);

   // abort outranks any write in the same cycle, including the overflow side effect.
   assign accept = bus.wr_en && bus.wr_ready && !abort;
   assign reject = bus.wr_en && !bus.wr_ready && !abort;
   assign push   = accept && (state == PH_B);
   assign pop    = bus.pix_valid && bus.pix_ready;

   assign word = (GRB_ORDER == ORDER_GRB) ? {g_q, r_q, bus.wr_data}
                                          : {r_q, g_q, bus.wr_data};

   ws2812b_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (abort),
      .din   ({bus.wr_latch, word}),
      .head  (head),
      .level (level)
   );

   assign bus.pix_valid = (level != '0);
   assign bus.pix_latch = head[PIXEL_W];
   assign bus.pix_data  = head[PIXEL_W-1:0];
   assign phase         = state;
   assign busy          = (level != '0) || (state != PH_R);

   // Assembler phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PH_R;
      else        state <= state_next;
   end

   // Next phase: advance on each accepted byte; abort or the unused code returns to R.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = PH_R;
      end else begin
         case (state)
            PH_R:    if (accept) state_next = PH_G;
            PH_G:    if (accept) state_next = PH_B;
            PH_B:    if (accept) state_next = PH_R;
            default: state_next = PH_R;
         endcase
      end
   end

   // R/G holding registers; deliberately left alone by abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
         g_q <= '0;
      end else begin
         if (accept && (state == PH_R)) r_q <= bus.wr_data;
         if (accept && (state == PH_G)) g_q <= bus.wr_data;
      end
   end

   // Sticky overflow: a dropped byte sets it and wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (reject)  overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_ws2812b_pixel_feeder.sv
// tb/tb_ws2812b_pixel_feeder.sv - directed self-checking bench for the pixel feeder
module tb_ws2812b_pixel_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_en = 1'b0;
   logic       wr_latch = 1'b0;
   logic       pix_ready = 1'b0;
   logic       abort = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [2:0] level0, level1;
   logic [1:0] phase0, phase1;
   logic       busy0, busy1, ovf0, ovf1;
   int         compared = 0;
   int         mismatched = 0;

   always #5 clk = ~clk;

   ws2812b_pixel_feeder_if bus0 ();
   ws2812b_pixel_feeder_if bus1 ();

   assign bus0.wr_data   = wr_data;
   assign bus0.wr_en     = wr_en;
   assign bus0.wr_latch  = wr_latch;
   assign bus0.pix_ready = pix_ready;
   assign bus1.wr_data   = wr_data;
   assign bus1.wr_en     = wr_en;
   assign bus1.wr_latch  = wr_latch;
   assign bus1.pix_ready = pix_ready;

   ws2812b_pixel_feeder #(.DEPTH(4), .GRB_ORDER(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .abort(abort), .clr_ovf(clr_ovf),
      .level(level0), .phase(phase0), .busy(busy0), .overflow(ovf0)
   );

   ws2812b_pixel_feeder #(.DEPTH(4), .GRB_ORDER(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .abort(abort), .clr_ovf(clr_ovf),
      .level(level1), .phase(phase1), .busy(busy1), .overflow(ovf1)
   );

   // Drives one byte for exactly one clock; returns 1 time unit after that edge.
   task automatic write_byte(input logic [7:0] b, input logic l);
      wr_data = b; wr_latch = l; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; wr_latch = 1'b0;
   endtask

   task automatic pop_one();
      pix_ready = 1'b1;
      @(posedge clk); #1;
      pix_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      compared++; if (bus0.wr_ready !== 1'b1) begin mismatched++; $display("FAIL reset_wr_ready: got %b want 1", bus0.wr_ready); end
      write_byte(8'h11, 1'b0); write_byte(8'h22, 1'b0); write_byte(8'h33, 1'b0); write_byte(8'h44, 1'b0);
      compared++; if (bus0.pix_valid !== 1'b1 || phase0 !== 2'd1) begin mismatched++; $display("FAIL pre_reset_state: got valid=%b phase=%0d want valid=1 phase=1", bus0.pix_valid, phase0); end
      #1 rst_n = 1'b0;
      #1;
      compared++; if (phase0 !== 2'd0) begin mismatched++; $display("FAIL async_reset_phase: got %0d want 0", phase0); end
      compared++; if (level0 !== 3'd0) begin mismatched++; $display("FAIL async_reset_level: got %0d want 0", level0); end
      compared++; if (bus0.pix_valid !== 1'b0) begin mismatched++; $display("FAIL async_reset_valid: got %b want 0", bus0.pix_valid); end
      compared++; if (bus0.pix_data !== 24'h0 || bus1.pix_data !== 24'h0) begin mismatched++; $display("FAIL async_reset_data: got %h/%h want 000000", bus0.pix_data, bus1.pix_data); end
      compared++; if (bus0.pix_latch !== 1'b0) begin mismatched++; $display("FAIL async_reset_latch: got %b want 0", bus0.pix_latch); end
      compared++; if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin mismatched++; $display("FAIL async_reset_ovf_busy: got ovf=%b busy=%b want 0 0", ovf0, busy0); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      compared++; if (bus0.wr_ready !== 1'b1 || phase0 !== 2'd0) begin mismatched++; $display("FAIL post_reset: got ready=%b phase=%0d want 1 0", bus0.wr_ready, phase0); end
   endtask

   task automatic test_single_pixel();
      pix_ready = 1'b1;
      write_byte(8'h11, 1'b0); write_byte(8'h22, 1'b0);
      compared++; if (bus0.pix_valid !== 1'b0 || phase0 !== 2'd2) begin mismatched++; $display("FAIL single_before_b: got valid=%b phase=%0d want 0 2", bus0.pix_valid, phase0); end
      wr_data = 8'h33; wr_latch = 1'b0; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; pix_ready = 1'b0;
      compared++; if (bus0.pix_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want 1", bus0.pix_valid); end
      compared++; if (bus0.pix_data !== 24'h221133) begin mismatched++; $display("FAIL single_grb_data: got %h want 221133", bus0.pix_data); end
      compared++; if (bus1.pix_data !== 24'h112233) begin mismatched++; $display("FAIL single_rgb_data: got %h want 112233", bus1.pix_data); end
      compared++; if (bus0.pix_latch !== 1'b0 || phase0 !== 2'd0) begin mismatched++; $display("FAIL single_latch_phase: got latch=%b phase=%0d want 0 0", bus0.pix_latch, phase0); end
      pop_one();
      compared++; if (bus0.pix_valid !== 1'b0 || level0 !== 3'd0 || busy0 !== 1'b0) begin mismatched++; $display("FAIL single_drain: got valid=%b level=%0d busy=%b want 0 0 0", bus0.pix_valid, level0, busy0); end
   endtask

   task automatic test_backpressure_overflow();
      logic [23:0] exp [4];
      exp[0] = 24'h050406; exp[1] = 24'h080709; exp[2] = 24'h0B0A0C; exp[3] = 24'h0E0D0F;
      pix_ready = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 3; k++) write_byte(8'(3 * p + k + 1), 1'b0);
      compared++; if (level0 !== 3'd4) begin mismatched++; $display("FAIL bp_level_full: got %0d want 4", level0); end
      write_byte(8'h0D, 1'b0); write_byte(8'h0E, 1'b0);
      compared++; if (phase0 !== 2'd2 || bus0.wr_ready !== 1'b0) begin mismatched++; $display("FAIL bp_stall: got phase=%0d ready=%b want 2 0", phase0, bus0.wr_ready); end
      write_byte(8'h0F, 1'b0);
      compared++; if (ovf0 !== 1'b1 || phase0 !== 2'd2 || level0 !== 3'd4) begin mismatched++; $display("FAIL bp_drop: got ovf=%b phase=%0d level=%0d want 1 2 4", ovf0, phase0, level0); end
      compared++; if (bus0.pix_data !== 24'h020103) begin mismatched++; $display("FAIL bp_head_stable: got %h want 020103", bus0.pix_data); end
      pop_one();
      compared++; if (level0 !== 3'd3 || bus0.wr_ready !== 1'b1) begin mismatched++; $display("FAIL bp_after_pop: got level=%0d ready=%b want 3 1", level0, bus0.wr_ready); end
      write_byte(8'h0F, 1'b0);
      compared++; if (level0 !== 3'd4 || phase0 !== 2'd0 || ovf0 !== 1'b1) begin mismatched++; $display("FAIL bp_retry: got level=%0d phase=%0d ovf=%b want 4 0 1", level0, phase0, ovf0); end
      clr_ovf = 1'b1;
      @(posedge clk); #1 clr_ovf = 1'b0;
      compared++; if (ovf0 !== 1'b0) begin mismatched++; $display("FAIL bp_clr_ovf: got %b want 0", ovf0); end
      for (int i = 0; i < 4; i++) begin
         compared++; if (bus0.pix_valid !== 1'b1 || bus0.pix_data !== exp[i]) begin mismatched++; $display("FAIL bp_drain_%0d: got valid=%b data=%h want 1 %h", i, bus0.pix_valid, bus0.pix_data, exp[i]); end
         pop_one();
      end
      compared++; if (level0 !== 3'd0) begin mismatched++; $display("FAIL bp_empty: got %0d want 0", level0); end
   endtask

   task automatic test_latch();
      pix_ready = 1'b0;
      write_byte(8'hAA, 1'b1); write_byte(8'hBB, 1'b1); write_byte(8'hCC, 1'b0);
      write_byte(8'h01, 1'b0); write_byte(8'h02, 1'b0); write_byte(8'h03, 1'b1);
      compared++; if (bus0.pix_latch !== 1'b0 || bus0.pix_data !== 24'hBBAACC) begin mismatched++; $display("FAIL latch_head_a: got latch=%b data=%h want 0 bbaacc", bus0.pix_latch, bus0.pix_data); end
      pop_one();
      compared++; if (bus0.pix_latch !== 1'b1 || bus0.pix_data !== 24'h020103) begin mismatched++; $display("FAIL latch_head_b: got latch=%b data=%h want 1 020103", bus0.pix_latch, bus0.pix_data); end
      pop_one();
      compared++; if (level0 !== 3'd0) begin mismatched++; $display("FAIL latch_empty: got %0d want 0", level0); end
   endtask

   task automatic test_simultaneous();
      logic [23:0] exp [2];
      exp[0] = 24'h504060; exp[1] = 24'h807090;
      pix_ready = 1'b0;
      write_byte(8'h10, 1'b0); write_byte(8'h20, 1'b0); write_byte(8'h30, 1'b0);
      write_byte(8'h40, 1'b0); write_byte(8'h50, 1'b0); write_byte(8'h60, 1'b0);
      write_byte(8'h70, 1'b0); write_byte(8'h80, 1'b0);
      compared++; if (level0 !== 3'd2) begin mismatched++; $display("FAIL simul_pre_level: got %0d want 2", level0); end
      pix_ready = 1'b1;
      write_byte(8'h90, 1'b0);
      pix_ready = 1'b0;
      compared++; if (level0 !== 3'd2) begin mismatched++; $display("FAIL simul_level: got %0d want 2", level0); end
      for (int i = 0; i < 2; i++) begin
         compared++; if (bus0.pix_data !== exp[i]) begin mismatched++; $display("FAIL simul_order_%0d: got %h want %h", i, bus0.pix_data, exp[i]); end
         pop_one();
      end
      compared++; if (bus0.pix_valid !== 1'b0) begin mismatched++; $display("FAIL simul_empty: got %b want 0", bus0.pix_valid); end
   endtask

   task automatic test_abort();
      pix_ready = 1'b0;
      write_byte(8'hA1, 1'b0); write_byte(8'hA2, 1'b0); write_byte(8'hA3, 1'b0);
      write_byte(8'hB1, 1'b0); write_byte(8'hB2, 1'b0); write_byte(8'hB3, 1'b0);
      write_byte(8'hC1, 1'b0);
      compared++; if (level0 !== 3'd2 || phase0 !== 2'd1) begin mismatched++; $display("FAIL abort_pre: got level=%0d phase=%0d want 2 1", level0, phase0); end
      abort = 1'b1; pix_ready = 1'b1;
      write_byte(8'hEE, 1'b0);
      abort = 1'b0; pix_ready = 1'b0;
      compared++; if (phase0 !== 2'd0 || level0 !== 3'd0 || bus0.pix_valid !== 1'b0) begin mismatched++; $display("FAIL abort_flush: got phase=%0d level=%0d valid=%b want 0 0 0", phase0, level0, bus0.pix_valid); end
      compared++; if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin mismatched++; $display("FAIL abort_ovf_busy: got ovf=%b busy=%b want 0 0", ovf0, busy0); end
      write_byte(8'h31, 1'b0); write_byte(8'h32, 1'b0); write_byte(8'h33, 1'b1);
      compared++; if (bus0.pix_valid !== 1'b1 || bus0.pix_data !== 24'h323133 || bus0.pix_latch !== 1'b1) begin mismatched++; $display("FAIL abort_fresh: got valid=%b data=%h latch=%b want 1 323133 1", bus0.pix_valid, bus0.pix_data, bus0.pix_latch); end
      compared++; if (bus1.pix_data !== 24'h313233 || level0 !== 3'd1) begin mismatched++; $display("FAIL abort_fresh_rgb: got data=%h level=%0d want 313233 1", bus1.pix_data, level0); end
      pop_one();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_pixel();
      test_backpressure_overflow();
      test_latch();
      test_simultaneous();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ws2812b_pixel_feeder.md
Name: ws2812b_pixel_feeder

Overview:
- Byte-to-pixel front end that sits directly upstream of the WS2812B serial driver.
- Takes colour bytes written by the CPU-side byte peripheral interface, assembles each R,G,B triplet into one 24-bit word in wire order, and queues words with a per-pixel latch flag in a small FIFO.
- Presents the FIFO head to the driver over a valid/ready handshake, so the CPU can run ahead of the 30 us-per-pixel serial rate.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- GRB_ORDER, 1: 1 packs {G,R,B}; 0 packs {R,G,B}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- wr_data  in  8  colour byte.
- wr_en  in  1  byte write strobe, one cycle per byte.
- wr_latch  in  1  sampled only with the third (B) byte; marks the pixel as last before latch.
- wr_ready  out  1  byte write will be accepted this cycle.
- abort  in  1  synchronous flush of the partial pixel and the FIFO.
- clr_ovf  in  1  clears the sticky overflow flag.
- pix_data  out  24  FIFO head word, MSB transmitted first.
- pix_valid  out  1  FIFO non-empty.
- pix_latch  out  1  latch flag of the head word.
- pix_ready  in  1  driver accepts the head word.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- phase  out  2  next byte expected: 0=R, 1=G, 2=B.
- busy  out  1  (level != 0) || (phase != 0).
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (async assert, sync release): phase=0, FIFO empty, level=0, pix_valid=0, pix_data=0, pix_latch=0, overflow=0, busy=0. wr_ready is 1 after reset.
- wr_ready = (phase != 2) || (level != DEPTH). It is a function of registers only and does not depend on same-cycle pix_ready.
- Accepted write (wr_en && wr_ready):
  - Phase R or G: store the byte in the R or G holding register, then advance phase.
  - Phase B: push {latch=wr_latch, word} into the FIFO, then return phase to 0.
  - Word packing: GRB_ORDER=1 gives {G,R,B}; GRB_ORDER=0 gives {R,G,B}.
- Rejected write (wr_en && !wr_ready): the byte is dropped, phase is unchanged, and overflow is set on the next cycle.
- clr_ovf clears overflow. If clr_ovf and a rejected write occur in the same cycle, set wins.
- Pop: occurs when pix_valid && pix_ready. The head advances on the next edge.
- Push and pop in the same cycle: level is unchanged and order is preserved. The full case cannot occur because a push is impossible while full.
- Show-ahead FIFO: pix_data and pix_latch are driven from the storage array at the read pointer.
  - Latency: third byte accepted in cycle N, FIFO empty → pix_valid=1 in cycle N+1.
  - While pix_valid && !pix_ready, pix_data and pix_latch hold stable.
- pix_valid may stay asserted across idle driver cycles. The driver samples only when its ready is high.
- Pointers: log2(DEPTH) bits each, wrapping naturally. level is a separate counter (0..DEPTH); no full/empty derivation from pointers.
- abort (priority over wr_en and pop):
  - Next cycle: phase=0, pointers=0, level=0, pix_valid=0.
  - The R/G holding registers are not cleared. overflow is unchanged.
  - A word the driver already accepted continues serialising unaffected.
- Async reset mid-operation clears everything immediately; there is no recovery of partial pixels.
- Assembler state machine: PH_R → PH_G → PH_B → PH_R. Only accepted writes or abort change state. The encoding of value 3 is unreachable and recovers to PH_R.

Decomposition:
- Package ws2812b_pkg holds:
  - PIXEL_W=24.
  - Phase encodings PH_R=0, PH_G=1, PH_B=2.
  - Order constants ORDER_RGB=0, ORDER_GRB=1.
  - Entry width PIXEL_W+1.
- Sub-module ws2812b_sync_fifo (params DEPTH, WIDTH):
  - Inputs: push, pop, flush.
  - Outputs: show-ahead head, level.
- The top level holds the assembler FSM, overflow logic, and packing.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with no clock edge → all outputs reach reset values immediately; wr_ready=1 after release.
- Single pixel: write 0x11, 0x22, 0x33 (latch=0), pix_ready=1 → pix_valid is high exactly one cycle after the third byte, with pix_data=0x221133 and pix_latch=0. With GRB_ORDER=0 the same writes give 0x112233.
- Back-pressure and overflow: pix_ready=0, write 4 pixels → level=4. Write 2 more bytes → phase=2, wr_ready=0. A third byte is dropped and overflow=1. One pix_ready pulse → level=3 and wr_ready=1; the retried byte is accepted and level=4. Then clr_ovf → overflow=0.
- Latch tagging: pixels A (latch=0) and B (latch=1) → pix_latch=0 while A is at the head and 1 while B is at the head. Writes to R/G with wr_latch=1 have no effect on the flag.
- Simultaneous push/pop: with level=2, pop in the same cycle as a third-byte push → level stays 2, and the words are popped in write order.
- Abort: one byte written and level=2, pulse abort together with wr_en and pix_ready → next cycle phase=0, level=0, pix_valid=0, overflow unchanged. A fresh 3-byte write then produces the correct word.
